// File: rtl/xcfi_pkg.sv
//------------------------------------------------------------------------------
// xcfi_pkg : shared widths, privilege constant and FSM state type for the
//            XCFI trace producer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package xcfi_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int NRET    = 1;
  localparam int ORDER_W = 64;

  localparam logic [1:0] MODE_M = 2'd3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    TRAP_PEND = 2'd1,
    HALTED    = 2'd2
  } xcfi_tg_state_t;

endpackage

`default_nettype wire

// File: rtl/xcfi_pc_checker.sv
//------------------------------------------------------------------------------
// xcfi_pc_checker : remembers the last emitted next-PC and raises a sticky
//                   error when the following retire does not continue from it.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xcfi_pc_checker #(
  parameter int XLEN = xcfi_pkg::XLEN
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            accept_i,
  input  logic            intr_i,
  input  logic [XLEN-1:0] pc_rdata_i,
  input  logic [XLEN-1:0] pc_wdata_i,
  output logic            err_o
);

  logic [XLEN-1:0] last_pc_q;
  logic            seen_q;
  logic            err_q;
  logic            err_d;

  // Trap entry legitimately breaks continuity, as does the first retire.
  always_comb begin
    err_d = err_q;
    if (accept_i && seen_q && !intr_i && (pc_rdata_i != last_pc_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      last_pc_q <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_d;
      if (accept_i) begin
        last_pc_q <= pc_wdata_i;
        seen_q    <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/xcfi_trace_gen.sv
//------------------------------------------------------------------------------
// xcfi_trace_gen : registers the per-cycle retirement event into the rvfi_*
//                  trace (order, intr, halt, x0 masking). Optional PC
//                  continuity check under XCFI_TRACE_PC_CHECK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xcfi_trace_gen
  import xcfi_pkg::*;
#(
  parameter int XLEN    = xcfi_pkg::XLEN,
  parameter int ILEN    = xcfi_pkg::ILEN,
  parameter int NRET    = xcfi_pkg::NRET,
  parameter int ORDER_W = xcfi_pkg::ORDER_W
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                ret_valid,
  input  logic [ILEN-1:0]     ret_insn,
  input  logic                ret_trap,
  input  logic                ret_halt,
  input  logic [XLEN-1:0]     ret_pc_rdata,
  input  logic [XLEN-1:0]     ret_pc_wdata,
  input  logic [4:0]          ret_rs1_addr,
  input  logic [4:0]          ret_rs2_addr,
  input  logic [4:0]          ret_rd_addr,
  input  logic [XLEN-1:0]     ret_rs1_rdata,
  input  logic [XLEN-1:0]     ret_rs2_rdata,
  input  logic [XLEN-1:0]     ret_rd_wdata,
  input  logic                ret_mem_en,
  input  logic [XLEN-1:0]     ret_mem_addr,
  input  logic [XLEN-1:0]     ret_mem_rdata,
  input  logic [XLEN-1:0]     ret_mem_wdata,
  input  logic [XLEN/8-1:0]   ret_mem_rmask,
  input  logic [XLEN/8-1:0]   ret_mem_wmask,
  output logic                rvfi_valid,
  output logic                rvfi_trap,
  output logic                rvfi_halt,
  output logic                rvfi_intr,
  output logic [ORDER_W-1:0]  rvfi_order,
  output logic [ILEN-1:0]     rvfi_insn,
  output logic [1:0]          rvfi_mode,
  output logic [XLEN-1:0]     rvfi_pc_rdata,
  output logic [XLEN-1:0]     rvfi_pc_wdata,
  output logic [XLEN-1:0]     rvfi_rs1_rdata,
  output logic [XLEN-1:0]     rvfi_rs2_rdata,
  output logic [XLEN-1:0]     rvfi_rd_wdata,
  output logic [XLEN-1:0]     rvfi_mem_addr,
  output logic [XLEN-1:0]     rvfi_mem_rdata,
  output logic [XLEN-1:0]     rvfi_mem_wdata,
  output logic [4:0]          rvfi_rs1_addr,
  output logic [4:0]          rvfi_rs2_addr,
  output logic [4:0]          rvfi_rd_addr,
  output logic [XLEN/8-1:0]   rvfi_mem_rmask,
  output logic [XLEN/8-1:0]   rvfi_mem_wmask,
  output logic                trace_err
);

  if (NRET != 1) begin : g_nret_check
    $error("xcfi_trace_gen supports only NRET == 1");
  end

  localparam logic [ORDER_W-1:0] ORDER_ONE = {{(ORDER_W-1){1'b0}}, 1'b1};

  xcfi_tg_state_t       state_q;
  xcfi_tg_state_t       state_d;
  logic [ORDER_W-1:0]   order_q;
  logic                 accept;
  logic                 intr;

  // Anything retiring while in reset or after halt never reaches the trace.
  assign accept = g_resetn && ret_valid && (state_q != HALTED);
  assign intr   = (state_q == TRAP_PEND);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (ret_halt) begin
        state_d = HALTED;
      end else if (ret_trap) begin
        state_d = TRAP_PEND;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q        <= RUN;
      order_q        <= '0;
      rvfi_valid     <= 1'b0;
      rvfi_trap      <= 1'b0;
      rvfi_halt      <= 1'b0;
      rvfi_intr      <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_mode      <= MODE_M;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
    end else begin
      state_q    <= state_d;
      rvfi_valid <= accept;
      rvfi_mode  <= MODE_M;
      if (accept) begin
        order_q        <= order_q + ORDER_ONE;
        rvfi_order     <= order_q;
        rvfi_trap      <= ret_trap;
        rvfi_halt      <= ret_halt;
        rvfi_intr      <= intr;
        rvfi_insn      <= ret_insn;
        rvfi_pc_rdata  <= ret_pc_rdata;
        rvfi_pc_wdata  <= ret_pc_wdata;
        rvfi_rs1_addr  <= ret_rs1_addr;
        rvfi_rs2_addr  <= ret_rs2_addr;
        rvfi_rd_addr   <= ret_rd_addr;
        rvfi_rs1_rdata <= ret_rs1_rdata;
        rvfi_rs2_rdata <= ret_rs2_rdata;
        rvfi_rd_wdata  <= (ret_rd_addr == 5'd0) ? '0 : ret_rd_wdata;
        rvfi_mem_addr  <= ret_mem_addr;
        rvfi_mem_rdata <= ret_mem_rdata;
        rvfi_mem_wdata <= ret_mem_wdata;
        rvfi_mem_rmask <= ret_mem_en ? ret_mem_rmask : '0;
        rvfi_mem_wmask <= ret_mem_en ? ret_mem_wmask : '0;
      end
    end
  end

`ifdef XCFI_TRACE_PC_CHECK_EN
  xcfi_pc_checker #(
    .XLEN (XLEN)
  ) u_pc_checker (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .accept_i   (accept),
    .intr_i     (intr),
    .pc_rdata_i (ret_pc_rdata),
    .pc_wdata_i (ret_pc_wdata),
    .err_o      (trace_err)
  );
`else
  assign trace_err = 1'b0;
`endif

endmodule

`default_nettype wire
